// File: rtl/pwm_dimmer_pkg.sv
// Shared definitions for the display-brightness PWM dimmer.
package pwm_dimmer_pkg;

    // Fade FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    // clk_in cycles between clk_pwm rising edges from the upstream divider
    localparam int TICK_PERIOD = 64;

endpackage

// File: rtl/pwm_tick_edge.sv
// One-register rising-edge detector for divider outputs sampled in the
// clk_in domain (the source is already a register in this domain, so no
// synchroniser is needed).
module pwm_tick_edge
    import pwm_dimmer_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_tick
);

    logic r_q;

    // Remember the previous sample of the divider output
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_sig;
        end
    end

    assign o_tick = i_sig & ~r_q;

endmodule

// File: rtl/pwm_dimmer.sv
// Display-brightness PWM with linear fade toward a software target.
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | level == target_reg, no fade in progress
//   UP      | level <  target_reg, stepping +1
//   DOWN    | level >  target_reg, stepping -1
//
// level only moves on the period boundary, so the duty of a running PWM
// period is never altered.
module pwm_dimmer
    import pwm_dimmer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FADE_DIV = 16
) (
    input  logic             i_clk_in,
    input  logic             i_reset,
    input  logic             i_clk_pwm,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_target_load,
    output logic             o_pwm_out,
    output logic [WIDTH-1:0] o_level,
    output logic             o_fading,
    output logic             o_fade_done
);

    localparam int             SC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(FADE_DIV - 1);

    logic             w_tick;
    logic             w_pb;
    logic [WIDTH-1:0] w_level_step;
    logic [1:0]       w_load_state;

    logic [WIDTH-1:0] r_pwm_cnt;
    logic             r_pwm_out;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_target;
    logic [SC_W-1:0]  r_step_cnt;
    logic [1:0]       r_state;
    logic             r_fade_done;

    pwm_tick_edge u_tick (
        .i_clk  (i_clk_in),
        .i_rst  (i_reset),
        .i_sig  (i_clk_pwm),
        .o_tick (w_tick)
    );

    assign w_pb = w_tick & i_enable & (r_pwm_cnt == '1);

    // Candidate next level for the current fade direction
    always_comb begin
        w_level_step = r_level;
        if (r_state == ST_UP) begin
            w_level_step = r_level + WIDTH'(1);
        end else if (r_state == ST_DOWN) begin
            w_level_step = r_level - WIDTH'(1);
        end
    end

    // Direction chosen when a new target is loaded against the current level
    always_comb begin
        w_load_state = ST_IDLE;
        if (i_target > r_level) begin
            w_load_state = ST_UP;
        end else if (i_target < r_level) begin
            w_load_state = ST_DOWN;
        end
    end

    // PWM period counter and registered compare output
    always_ff @(posedge i_clk_in or posedge i_reset) begin
        if (i_reset) begin
            r_pwm_cnt <= '0;
            r_pwm_out <= 1'b0;
        end else begin
            if (w_tick && i_enable) begin
                r_pwm_cnt <= r_pwm_cnt + WIDTH'(1);
            end
            r_pwm_out <= i_enable & (r_pwm_cnt < r_level);
        end
    end

    // Fade FSM: target capture has priority over a coincident boundary step
    always_ff @(posedge i_clk_in or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_level     <= '0;
            r_target    <= '0;
            r_step_cnt  <= '0;
            r_fade_done <= 1'b0;
        end else begin
            r_fade_done <= 1'b0;
            if (i_target_load) begin
                r_target   <= i_target;
                r_step_cnt <= '0;
                r_state    <= w_load_state;
                if (w_load_state == ST_IDLE) begin
                    r_fade_done <= 1'b1;
                end
            end else if (w_pb && (r_state != ST_IDLE)) begin
                if (r_step_cnt == SC_LAST) begin
                    r_step_cnt <= '0;
                    r_level    <= w_level_step;
                    if (w_level_step == r_target) begin
                        r_state     <= ST_IDLE;
                        r_fade_done <= 1'b1;
                    end
                end else begin
                    r_step_cnt <= r_step_cnt + SC_W'(1);
                end
            end
        end
    end

    assign o_pwm_out   = r_pwm_out;
    assign o_level     = r_level;
    assign o_fading    = (r_state != ST_IDLE);
    assign o_fade_done = r_fade_done;

endmodule

// File: tb/tb_pwm_dimmer.sv
// Self-checking bench for pwm_dimmer. clk_pwm is accelerated to one rising
// edge every 2 clk_in cycles so full fades fit in a short run:
//   u_d8: WIDTH=8, FADE_DIV=1 -> one PWM period = 256 ticks = 512 cycles
//   u_d4: WIDTH=4, FADE_DIV=3 -> one PWM period = 16 ticks = 32 cycles,
//         one fade step every 3 periods = 96 cycles
// fade_done arrivals are scoreboarded: the expected final level is queued
// when a target is loaded and popped when the pulse appears.
module tb_pwm_dimmer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_pwm;
    logic       en;

    logic [7:0] tgt8;
    logic       ld8;
    logic       pwm8;
    logic [7:0] lvl8;
    logic       fad8;
    logic       done8;

    logic [3:0] tgt4;
    logic       ld4;
    logic       pwm4;
    logic [3:0] lvl4;
    logic       fad4;
    logic       done4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;

    logic [7:0] q8[$];
    logic [3:0] q4[$];

    pwm_dimmer #(.WIDTH(8), .FADE_DIV(1)) u_d8 (
        .i_clk_in      (clk),
        .i_reset       (rst),
        .i_clk_pwm     (clk_pwm),
        .i_enable      (en),
        .i_target      (tgt8),
        .i_target_load (ld8),
        .o_pwm_out     (pwm8),
        .o_level       (lvl8),
        .o_fading      (fad8),
        .o_fade_done   (done8)
    );

    pwm_dimmer #(.WIDTH(4), .FADE_DIV(3)) u_d4 (
        .i_clk_in      (clk),
        .i_reset       (rst),
        .i_clk_pwm     (clk_pwm),
        .i_enable      (en),
        .i_target      (tgt4),
        .i_target_load (ld4),
        .o_pwm_out     (pwm4),
        .o_level       (lvl4),
        .o_fading      (fad4),
        .o_fade_done   (done4)
    );

    always #5 clk = ~clk;

    // Divider stand-in: one clk_pwm rising edge every 2 clk_in cycles
    initial begin
        clk_pwm = 1'b0;
        forever begin
            @(posedge clk);
            #1 clk_pwm = 1'b1;
            @(posedge clk);
            #1 clk_pwm = 1'b0;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done8 === 1'b1) done8_cnt++;
        if (done4 === 1'b1) done4_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load8(input logic [7:0] t);
        @(posedge clk);
        #1 tgt8 = t; ld8 = 1'b1;
        @(posedge clk);
        #1 ld8 = 1'b0;
    endtask

    task automatic load4(input logic [3:0] t);
        @(posedge clk);
        #1 tgt4 = t; ld4 = 1'b1;
        @(posedge clk);
        #1 ld4 = 1'b0;
    endtask

    task automatic wait_chg8(input int budget, output bit ok);
        logic [7:0] prev;
        prev = lvl8;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (lvl8 !== prev) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int hi;
        int d0;
        @(negedge clk);
        checks++;
        if (lvl8 !== 8'h00 || pwm8 !== 1'b0 || fad8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: level=%h pwm=%b fading=%b done=%b, required 00 0 0 0", lvl8, pwm8, fad8, done8);
        end
        checks++;
        if (lvl4 !== 4'h0 || fad4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_values_w4: level=%h fading=%b, required 0 0", lvl4, fad4);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        hi = 0;
        repeat (1024) begin
            @(negedge clk);
            if (pwm8 === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL duty_level0: high cycles=%0d, required 0", hi);
        end
        d0 = done8_cnt;
        load8(8'h80);
        for (int i = 0; i < 2100 && lvl8 !== 8'h03; i++) @(negedge clk);
        checks++;
        if (lvl8 !== 8'h03 || fad8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefade: level=%h fading=%b, required 03 1", lvl8, fad8);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lvl8 !== 8'h00 || pwm8 !== 1'b0 || fad8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: level=%h pwm=%b fading=%b done=%b, required 00 0 0 0", lvl8, pwm8, fad8, done8);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (lvl8 !== 8'h00 || fad8 !== 1'b0 || done8_cnt != d0) begin
            errors++;
            $display("FAIL reset_abort: level=%h fading=%b fade_done pulses=%0d, required 00 0 0", lvl8, fad8, done8_cnt - d0);
        end
    endtask

    task automatic test_fade_up();
        logic [7:0] prev;
        logic [7:0] exp;
        int t_prev;
        int nchg;
        int d0;
        bit seen;
        d0 = done8_cnt;
        q8.push_back(8'h10);
        load8(8'h10);
        prev = lvl8;
        t_prev = -1;
        nchg = 0;
        seen = 1'b0;
        for (int i = 0; i < 17 * 512 && !seen; i++) begin
            @(negedge clk);
            if (lvl8 !== prev) begin
                nchg++;
                checks++;
                if (lvl8 !== prev + 8'd1) begin
                    errors++;
                    $display("FAIL fade_up_step: level=%h, required %h", lvl8, prev + 8'd1);
                end
                if (t_prev >= 0) begin
                    checks++;
                    if (cyc - t_prev != 512) begin
                        errors++;
                        $display("FAIL fade_up_interval: cycles=%0d, required 512", cyc - t_prev);
                    end
                end
                t_prev = cyc;
                prev = lvl8;
            end
            if (done8 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fade_up_timeout: no fade_done, level=%h", lvl8);
        end else if (q8.size() == 0) begin
            errors++;
            $display("FAIL fade_up_sb: fade_done with no expected arrival queued");
        end else begin
            exp = q8.pop_front();
            if (lvl8 !== exp) begin
                errors++;
                $display("FAIL fade_up_arrival: level=%h, required %h", lvl8, exp);
            end
        end
        checks++;
        if (nchg != 16 || fad8 !== 1'b0) begin
            errors++;
            $display("FAIL fade_up_end: steps=%0d fading=%b, required 16 0", nchg, fad8);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done8_cnt - d0 != 1) begin
            errors++;
            $display("FAIL fade_up_done_count: pulses=%0d, required 1", done8_cnt - d0);
        end
    endtask

    task automatic test_duty();
        int hi;
        hi = 0;
        repeat (512) begin
            @(negedge clk);
            if (pwm8 === 1'b1) hi++;
        end
        checks++;
        if (hi != 32) begin
            errors++;
            $display("FAIL duty_0x10: high cycles=%0d of 512, required 32", hi);
        end
    endtask

    task automatic test_max_w4();
        logic [3:0] prev;
        logic [3:0] exp;
        int t_prev;
        int hi;
        bit seen;
        q4.push_back(4'hF);
        load4(4'hF);
        prev = lvl4;
        t_prev = -1;
        seen = 1'b0;
        for (int i = 0; i < 16 * 96 + 200 && !seen; i++) begin
            @(negedge clk);
            if (lvl4 !== prev) begin
                checks++;
                if (lvl4 !== prev + 4'd1) begin
                    errors++;
                    $display("FAIL w4_step: level=%h, required %h", lvl4, prev + 4'd1);
                end
                if (t_prev >= 0) begin
                    checks++;
                    if (cyc - t_prev != 96) begin
                        errors++;
                        $display("FAIL w4_fade_div_interval: cycles=%0d, required 96", cyc - t_prev);
                    end
                end
                t_prev = cyc;
                prev = lvl4;
            end
            if (done4 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL w4_timeout: no fade_done, level=%h", lvl4);
        end else if (q4.size() == 0) begin
            errors++;
            $display("FAIL w4_sb: fade_done with no expected arrival queued");
        end else begin
            exp = q4.pop_front();
            if (lvl4 !== exp) begin
                errors++;
                $display("FAIL w4_arrival: level=%h, required %h", lvl4, exp);
            end
        end
        repeat (4) @(negedge clk);
        hi = 0;
        repeat (32) begin
            @(negedge clk);
            if (pwm4 === 1'b1) hi++;
        end
        checks++;
        if (hi != 30) begin
            errors++;
            $display("FAIL duty_max: high cycles=%0d of 32, required 30", hi);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] l0;
        logic [7:0] prev;
        logic [7:0] exp;
        int d0;
        bit ok;
        bit seen;
        d0 = done8_cnt;
        load8(8'h30);
        wait_chg8(600, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL retarget_first_step: timeout, level=%h", lvl8);
        end
        l0 = lvl8;
        // Next boundary is exactly one period after the step just observed
        repeat (511) @(posedge clk);
        #1 tgt8 = 8'h30; ld8 = 1'b1;
        @(posedge clk);
        #1 ld8 = 1'b0;
        @(negedge clk);
        checks++;
        if (lvl8 !== l0 || fad8 !== 1'b1) begin
            errors++;
            $display("FAIL coincident_load: level=%h fading=%b, required %h 1", lvl8, fad8, l0);
        end
        repeat (511) @(posedge clk);
        @(negedge clk);
        checks++;
        if (lvl8 !== l0) begin
            errors++;
            $display("FAIL coincident_hold: level=%h, required %h", lvl8, l0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (lvl8 !== l0 + 8'd1) begin
            errors++;
            $display("FAIL coincident_resume: level=%h, required %h", lvl8, l0 + 8'd1);
        end
        q8.push_back(8'h08);
        load8(8'h08);
        @(negedge clk);
        checks++;
        if (lvl8 !== l0 + 8'd1 || fad8 !== 1'b1) begin
            errors++;
            $display("FAIL retarget_load: level=%h fading=%b, required %h 1", lvl8, fad8, l0 + 8'd1);
        end
        prev = lvl8;
        seen = 1'b0;
        for (int i = 0; i < 12 * 512 && !seen; i++) begin
            @(negedge clk);
            if (lvl8 !== prev) begin
                checks++;
                if (lvl8 !== prev - 8'd1) begin
                    errors++;
                    $display("FAIL retarget_down_step: level=%h, required %h", lvl8, prev - 8'd1);
                end
                prev = lvl8;
            end
            if (done8 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL retarget_timeout: no fade_done, level=%h", lvl8);
        end else if (q8.size() == 0) begin
            errors++;
            $display("FAIL retarget_sb: fade_done with no expected arrival queued");
        end else begin
            exp = q8.pop_front();
            if (lvl8 !== exp) begin
                errors++;
                $display("FAIL retarget_arrival: level=%h, required %h", lvl8, exp);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done8_cnt - d0 != 1 || fad8 !== 1'b0) begin
            errors++;
            $display("FAIL retarget_done_count: pulses=%0d fading=%b, required 1 0", done8_cnt - d0, fad8);
        end
    endtask

    task automatic test_enable();
        logic [7:0] l0;
        logic [7:0] exp;
        int hi;
        int d0;
        bit moved;
        bit ok;
        bit seen;
        d0 = done8_cnt;
        q8.push_back(8'h0C);
        load8(8'h0C);
        wait_chg8(600, ok);
        checks++;
        if (!ok || lvl8 !== 8'h09) begin
            errors++;
            $display("FAIL enable_first_step: level=%h, required 09", lvl8);
        end
        @(posedge clk);
        #1 en = 1'b0;
        l0 = lvl8;
        @(posedge clk);
        hi = 0;
        moved = 1'b0;
        repeat (3 * 512) begin
            @(negedge clk);
            if (pwm8 === 1'b1) hi++;
            if (lvl8 !== l0 || fad8 !== 1'b1) moved = 1'b1;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL enable_off_pwm: high cycles=%0d, required 0", hi);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL enable_off_freeze: level=%h fading=%b, required %h 1", lvl8, fad8, l0);
        end
        @(posedge clk);
        #1 en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 * 512 && !seen; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL enable_resume_timeout: no fade_done, level=%h", lvl8);
        end else if (q8.size() == 0) begin
            errors++;
            $display("FAIL enable_sb: fade_done with no expected arrival queued");
        end else begin
            exp = q8.pop_front();
            if (lvl8 !== exp) begin
                errors++;
                $display("FAIL enable_arrival: level=%h, required %h", lvl8, exp);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done8_cnt - d0 != 1) begin
            errors++;
            $display("FAIL enable_done_count: pulses=%0d, required 1", done8_cnt - d0);
        end
    endtask

    task automatic test_equal();
        logic [7:0] exp;
        q8.push_back(8'h0C);
        load8(8'h0C);
        @(negedge clk);
        checks++;
        if (done8 !== 1'b1 || fad8 !== 1'b0) begin
            errors++;
            $display("FAIL equal_done: fade_done=%b fading=%b, required 1 0", done8, fad8);
        end else if (q8.size() == 0) begin
            errors++;
            $display("FAIL equal_sb: fade_done with no expected arrival queued");
        end else begin
            exp = q8.pop_front();
            if (lvl8 !== exp) begin
                errors++;
                $display("FAIL equal_level: level=%h, required %h", lvl8, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL equal_pulse_width: fade_done=%b, required 0", done8);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        tgt8 = 8'h00;
        ld8  = 1'b0;
        tgt4 = 4'h0;
        ld4  = 1'b0;
        repeat (3) @(posedge clk);

        test_reset();
        test_fade_up();
        test_duty();
        test_max_w4();
        test_back_to_back();
        test_enable();
        test_equal();

        checks++;
        if (q8.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending w8=%0d w4=%0d, required 0 0", q8.size(), q4.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
